// File: rtl/cap_mem_wr_ser_if.sv
// Command/memory/response bundle for the capability-store serializer.
// The slave modport is the serializer's view; master is the surrounding environment.
interface cap_mem_wr_ser_if;
    logic        cmd_req;
    logic        cmd_gnt;
    logic [31:0] cmd_addr;
    logic        cmd_tag;
    logic [31:0] cmd_lo;
    logic [31:0] cmd_hi;
    logic        data_req;
    logic        data_gnt;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [32:0] data_wdata;
    logic        data_rvalid;
    logic        data_err;
    logic        rsp_valid;
    logic        rsp_err;

    modport slave (
        input  cmd_req, cmd_addr, cmd_tag, cmd_lo, cmd_hi,
        input  data_gnt, data_rvalid, data_err,
        output cmd_gnt,
        output data_req, data_we, data_be, data_addr, data_wdata,
        output rsp_valid, rsp_err
    );

    modport master (
        output cmd_req, cmd_addr, cmd_tag, cmd_lo, cmd_hi,
        output data_gnt, data_rvalid, data_err,
        input  cmd_gnt,
        input  data_req, data_we, data_be, data_addr, data_wdata,
        input  rsp_valid, rsp_err
    );
endinterface

// File: rtl/cap_mem_wr_ser.sv
// Splits a 65-bit tagged capability store into two tagged 32-bit memory writes.
// Optional macro CHERIOT_CAPSTORE_ABORT_EN: a beat-0 error skips the second beat.
module cap_mem_wr_ser #(
    parameter logic [31:0] MemStartAddr = 32'h8000_0000,
    parameter logic [31:0] MemSizeBytes = 32'h0300_0000
) (
    input logic             clk_i,
    input logic             rst_ni,
    cap_mem_wr_ser_if.slave bus
);
    localparam int unsigned AddrW = 32;
    localparam int unsigned ExtW  = AddrW + 1;
    localparam int unsigned BeW   = 4;
    localparam int unsigned DataW = AddrW + 1;

`ifdef CHERIOT_CAPSTORE_ABORT_EN
    localparam bit AbortEn = 1'b1;
`else
    localparam bit AbortEn = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    typedef struct packed {
        logic [AddrW-1:0] addr;
        logic             tag;
        logic [AddrW-1:0] lo;
        logic [AddrW-1:0] hi;
    } cmd_t;

    state_t          state;
    cmd_t            cmd_q;
    logic            err_acc;
    logic            grant;
    logic            legal;
    logic [ExtW-1:0] addr_x;
    logic [ExtW-1:0] end_x;
    logic [ExtW-1:0] win_lo;
    logic [ExtW-1:0] win_hi;

    // Window check in 33 bits so neither addr+8 nor start+size can wrap.
    assign addr_x = ExtW'(bus.cmd_addr);
    assign end_x  = addr_x + ExtW'(8);
    assign win_lo = ExtW'(MemStartAddr);
    assign win_hi = ExtW'(MemStartAddr) + ExtW'(MemSizeBytes);
    assign legal  = (bus.cmd_addr[2:0] == 3'b000) && (addr_x >= win_lo) && (end_x <= win_hi);

    // Grant is held off while reset is asserted so no command is lost to the reset.
    assign grant       = rst_ni && (state == IDLE) && bus.cmd_req;
    assign bus.cmd_gnt = grant;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state          <= IDLE;
            cmd_q          <= '0;
            err_acc        <= 1'b0;
            bus.data_req   <= 1'b0;
            bus.data_we    <= 1'b0;
            bus.data_be    <= '0;
            bus.data_addr  <= '0;
            bus.data_wdata <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        cmd_q   <= '{addr: bus.cmd_addr, tag: bus.cmd_tag,
                                     lo: bus.cmd_lo, hi: bus.cmd_hi};
                        err_acc <= 1'b0;
                        if (legal) begin
                            state          <= REQ0;
                            bus.data_req   <= 1'b1;
                            bus.data_we    <= 1'b1;
                            bus.data_be    <= BeW'(4'hF);
                            bus.data_addr  <= bus.cmd_addr;
                            bus.data_wdata <= DataW'({bus.cmd_tag, bus.cmd_lo});
                        end else begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                        end
                    end
                end
                REQ0: begin
                    if (bus.data_gnt) begin
                        state          <= WAIT0;
                        bus.data_req   <= 1'b0;
                        bus.data_we    <= 1'b0;
                        bus.data_be    <= '0;
                        bus.data_addr  <= '0;
                        bus.data_wdata <= '0;
                    end else begin
                        bus.data_addr  <= cmd_q.addr;
                        bus.data_wdata <= DataW'({cmd_q.tag, cmd_q.lo});
                    end
                end
                WAIT0: begin
                    if (bus.data_rvalid) begin
                        if (AbortEn && bus.data_err) begin
                            state         <= RESP;
                            err_acc       <= 1'b1;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                        end else begin
                            state          <= REQ1;
                            err_acc        <= err_acc | bus.data_err;
                            bus.data_req   <= 1'b1;
                            bus.data_we    <= 1'b1;
                            bus.data_be    <= BeW'(4'hF);
                            bus.data_addr  <= cmd_q.addr + AddrW'(4);
                            bus.data_wdata <= DataW'({cmd_q.tag, cmd_q.hi});
                        end
                    end
                end
                REQ1: begin
                    if (bus.data_gnt) begin
                        state          <= WAIT1;
                        bus.data_req   <= 1'b0;
                        bus.data_we    <= 1'b0;
                        bus.data_be    <= '0;
                        bus.data_addr  <= '0;
                        bus.data_wdata <= '0;
                    end else begin
                        bus.data_addr  <= cmd_q.addr + AddrW'(4);
                        bus.data_wdata <= DataW'({cmd_q.tag, cmd_q.hi});
                    end
                end
                WAIT1: begin
                    if (bus.data_rvalid) begin
                        state         <= RESP;
                        err_acc       <= err_acc | bus.data_err;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= err_acc | bus.data_err;
                    end
                end
                RESP: begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_err   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cap_mem_wr_ser.sv
// Directed bench for cap_mem_wr_ser: cycle-exact protocol walk per command,
// checking legal/illegal addresses, stalls, errors, reset and back-to-back grants.
module tb_cap_mem_wr_ser;
    logic clk_i;
    logic rst_ni;
    int   n_total;
    int   n_bad;

    cap_mem_wr_ser_if bus ();

    cap_mem_wr_ser dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

`ifdef CHERIOT_CAPSTORE_ABORT_EN
    localparam int AbortBeats = 1;
`else
    localparam int AbortBeats = 2;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Walks one command from its grant cycle to the idle cycle after completion.
    task automatic run_cmd(input string nm, input logic [31:0] a, input logic t,
                           input logic [31:0] lo, input logic [31:0] hi,
                           input int dly, input logic e0, input logic e1,
                           input logic hold, input logic spur,
                           input int exp_beats, input logic exp_err);
        logic [31:0] exp_a;
        logic [32:0] exp_d;
        bus.cmd_req  = 1'b1;
        bus.cmd_addr = a;
        bus.cmd_tag  = t;
        bus.cmd_lo   = lo;
        bus.cmd_hi   = hi;
        #1;
        chk({nm, ".gnt"}, 64'(bus.cmd_gnt), 64'd1);
        tick();
        bus.cmd_req = hold;
        if (exp_beats == 0) begin
            #1;
            chk({nm, ".noreq"}, 64'(bus.data_req), 64'd0);
            chk({nm, ".rspv"}, 64'(bus.rsp_valid), 64'd1);
            chk({nm, ".rsperr"}, 64'(bus.rsp_err), 64'd1);
        end else begin
            for (int b = 0; b < exp_beats; b++) begin
                exp_a = (b == 0) ? a : a + 32'd4;
                exp_d = {t, (b == 0) ? lo : hi};
                for (int d = 0; d <= dly; d++) begin
                    bus.data_gnt    = (d == dly);
                    bus.data_rvalid = spur && (d < dly);
                    bus.data_err    = spur && (d < dly);
                    #1;
                    chk($sformatf("%s.b%0d.req", nm, b), 64'(bus.data_req), 64'd1);
                    chk($sformatf("%s.b%0d.addr", nm, b), 64'(bus.data_addr), 64'(exp_a));
                    chk($sformatf("%s.b%0d.wdata", nm, b), 64'(bus.data_wdata), 64'(exp_d));
                    chk($sformatf("%s.b%0d.webe", nm, b), 64'({bus.data_we, bus.data_be}), 64'h1F);
                    chk($sformatf("%s.b%0d.gnt", nm, b), 64'(bus.cmd_gnt), 64'd0);
                    tick();
                end
                bus.data_gnt    = 1'b0;
                bus.data_rvalid = 1'b1;
                bus.data_err    = (b == 0) ? e0 : e1;
                #1;
                chk($sformatf("%s.w%0d.req", nm, b), 64'(bus.data_req), 64'd0);
                chk($sformatf("%s.w%0d.rspv", nm, b), 64'(bus.rsp_valid), 64'd0);
                tick();
                bus.data_rvalid = 1'b0;
                bus.data_err    = 1'b0;
            end
            #1;
            chk({nm, ".rspv"}, 64'(bus.rsp_valid), 64'd1);
            chk({nm, ".rsperr"}, 64'(bus.rsp_err), 64'(exp_err));
            chk({nm, ".rspreq"}, 64'(bus.data_req), 64'd0);
        end
        chk({nm, ".rspgnt"}, 64'(bus.cmd_gnt), 64'd0);
        tick();
        #1;
        chk({nm, ".idlev"}, 64'(bus.rsp_valid), 64'd0);
        chk({nm, ".idlereq"}, 64'(bus.data_req), 64'd0);
    endtask

    initial begin
        n_total         = 0;
        n_bad           = 0;
        rst_ni          = 1'b0;
        bus.cmd_req     = 1'b1;
        bus.cmd_addr    = 32'h8000_0000;
        bus.cmd_tag     = 1'b1;
        bus.cmd_lo      = '0;
        bus.cmd_hi      = '0;
        bus.data_gnt    = 1'b0;
        bus.data_rvalid = 1'b0;
        bus.data_err    = 1'b0;
        tick();
        tick();
        chk("rst.gnt", 64'(bus.cmd_gnt), 64'd0);
        chk("rst.req", 64'(bus.data_req), 64'd0);
        chk("rst.rspv", 64'(bus.rsp_valid), 64'd0);
        chk("rst.wdata", 64'(bus.data_wdata), 64'd0);
        bus.cmd_req = 1'b0;
        rst_ni      = 1'b1;
        tick();

        run_cmd("basic", 32'h8000_0010, 1'b1, 32'h8000_0020, 32'h1234_5678, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        run_cmd("misal", 32'h8000_0014, 1'b1, 32'h1, 32'h2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        run_cmd("endov", 32'h82FF_FFFC, 1'b1, 32'h1, 32'h2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        run_cmd("below", 32'h7FFF_FFF8, 1'b1, 32'h1, 32'h2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        run_cmd("wrap", 32'hFFFF_FFF8, 1'b1, 32'h1, 32'h2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        run_cmd("start", 32'h8000_0000, 1'b1, 32'hAAAA_5555, 32'h0F0F_F0F0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        run_cmd("stall", 32'h82FF_FFF8, 1'b1, 32'hCAFE_0001, 32'hBEEF_0002, 3, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
        run_cmd("err0", 32'h8000_0040, 1'b1, 32'h1111_1111, 32'h2222_2222, 0, 1'b1, 1'b0, 1'b0, 1'b0, AbortBeats, 1'b1);
        run_cmd("err1", 32'h8000_0048, 1'b1, 32'h3333_3333, 32'h4444_4444, 1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b1);

        // Reset while waiting for the beat-1 response; the late rvalid must be ignored.
        bus.cmd_req  = 1'b1;
        bus.cmd_addr = 32'h8000_0100;
        bus.cmd_tag  = 1'b1;
        bus.cmd_lo   = 32'h5555_0000;
        bus.cmd_hi   = 32'h6666_0000;
        #1;
        chk("rstw.gnt", 64'(bus.cmd_gnt), 64'd1);
        tick();
        bus.cmd_req  = 1'b0;
        bus.data_gnt = 1'b1;
        #1;
        chk("rstw.b0req", 64'(bus.data_req), 64'd1);
        tick();
        bus.data_gnt    = 1'b0;
        bus.data_rvalid = 1'b1;
        tick();
        bus.data_rvalid = 1'b0;
        bus.data_gnt    = 1'b1;
        #1;
        chk("rstw.b1addr", 64'(bus.data_addr), 64'h8000_0104);
        tick();
        bus.data_gnt = 1'b0;
        rst_ni       = 1'b0;
        tick();
        rst_ni          = 1'b1;
        bus.data_rvalid = 1'b1;
        #1;
        chk("rstw.req", 64'(bus.data_req), 64'd0);
        chk("rstw.rspv", 64'(bus.rsp_valid), 64'd0);
        chk("rstw.webe", 64'({bus.data_we, bus.data_be}), 64'd0);
        tick();
        bus.data_rvalid = 1'b0;
        #1;
        chk("rstw.rspv2", 64'(bus.rsp_valid), 64'd0);
        chk("rstw.req2", 64'(bus.data_req), 64'd0);
        tick();
        run_cmd("after", 32'h8000_0200, 1'b1, 32'h7777_7777, 32'h8888_8888, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0);

        // Back-to-back: request held high across the first command.
        run_cmd("b2b0", 32'h8000_0300, 1'b0, 32'h9999_0001, 32'h9999_0002, 0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0);
        run_cmd("b2b1", 32'h8000_0308, 1'b0, 32'hABCD_0001, 32'hABCD_0002, 1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
